// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and one memory completer (slave).
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH-entry memory with programmable wait states
// and an error response for out-of-range local indices.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic           pclk,
    input  logic           presetn,
    apb_slave_mem_if.slave apb
);
    localparam int          IDX_W   = ADDR_WIDTH - 1;
    localparam logic [31:0] DEPTH_U = DEPTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    typedef struct packed {
        logic                  write;
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic [1:0]            state_q, state_d, phase;
    logic [3:0]            cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  set_ready, wr_en;
    logic                  cur_write, cur_err;
    logic [IDX_W-1:0]      cur_idx;
    logic [31:0]           cur_idx_ext, wr_idx_ext;
    logic [DATA_WIDTH-1:0] rd_data;

    // paddr MSB selects between instances upstream; nothing to decode here.
    logic unused_sel;
    assign unused_sel = apb.paddr[ADDR_WIDTH-1];

    // The APB setup cycle is recognised combinationally so that SETUP work
    // lands on the edge ending it; only IDLE and ACCESS are ever registered.
    always_comb begin
        if (state_q == ACCESS)
            phase = ACCESS;
        else if (apb.psel && !apb.penable)
            phase = SETUP;
        else
            phase = IDLE;
    end

    // A zero-wait read must fetch from the live bus address, not the capture.
    assign cur_idx     = (phase == SETUP) ? apb.paddr[IDX_W-1:0] : req_q.idx;
    assign cur_write   = (phase == SETUP) ? apb.pwrite : req_q.write;
    assign cur_idx_ext = 32'(cur_idx);
    assign cur_err     = (cur_idx_ext >= DEPTH_U);
    assign wr_idx_ext  = 32'(req_q.idx);

    // Out-of-range indices match no entry, so a read returns zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (cur_idx_ext == 32'(i)) rd_data = mem_q[i];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        set_ready = 1'b0;
        wr_en     = 1'b0;

        case (phase)
            SETUP: begin
                req_d.write = apb.pwrite;
                req_d.idx   = apb.paddr[IDX_W-1:0];
                req_d.wdata = apb.pwdata;
                cnt_d       = 4'(WAIT_CYCLES);
                state_d     = ACCESS;
                set_ready   = (WAIT_CYCLES == 0);
            end
            ACCESS: begin
                if (!(apb.psel && apb.penable)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (pready_q) begin
                    wr_en   = req_q.write && !cur_err;
                    state_d = IDLE;
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d     = '0;
                    set_ready = 1'b1;
                end
            end
            default: ;
        endcase

        if (set_ready) begin
            pready_d  = 1'b1;
            pslverr_d = cur_err;
            if (!cur_write) prdata_d = rd_data;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wr_en && wr_idx_ext == 32'(i)) mem_q[i] <= req_q.wdata;
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed plus randomized bench for apb_slave_mem at three wait-state settings.
module tb_apb_slave_mem;
    logic       pclk, presetn;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    int         tgt;
    logic       pready_m, pslverr_m;
    logic [7:0] prdata_m;

    int checks   = 0;
    int failures = 0;

    int         wt [3] = '{0, 3, 2};
    logic [7:0] mdl [3][64];

    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if0 ();
    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if1 ();
    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if2 ();

    assign if0.psel = psel && (tgt == 0);
    assign if1.psel = psel && (tgt == 1);
    assign if2.psel = psel && (tgt == 2);
    assign if0.penable = penable; assign if1.penable = penable; assign if2.penable = penable;
    assign if0.pwrite  = pwrite;  assign if1.pwrite  = pwrite;  assign if2.pwrite  = pwrite;
    assign if0.paddr   = paddr;   assign if1.paddr   = paddr;   assign if2.paddr   = paddr;
    assign if0.pwdata  = pwdata;  assign if1.pwdata  = pwdata;  assign if2.pwdata  = pwdata;

    assign pready_m  = (tgt == 0) ? if0.pready  : (tgt == 1) ? if1.pready  : if2.pready;
    assign pslverr_m = (tgt == 0) ? if0.pslverr : (tgt == 1) ? if1.pslverr : if2.pslverr;
    assign prdata_m  = (tgt == 0) ? if0.prdata  : (tgt == 1) ? if1.prdata  : if2.prdata;

    apb_slave_mem #(.WAIT_CYCLES(0)) u0 (.pclk(pclk), .presetn(presetn), .apb(if0.slave));
    apb_slave_mem #(.WAIT_CYCLES(3)) u1 (.pclk(pclk), .presetn(presetn), .apb(if1.slave));
    apb_slave_mem #(.WAIT_CYCLES(2)) u2 (.pclk(pclk), .presetn(presetn), .apb(if2.slave));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int t = 0; t < 3; t++)
            for (int i = 0; i < 64; i++) mdl[t][i] = 8'h00;
    endtask

    task automatic idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    // Bus inputs are scrambled during ACCESS: the slave must use its capture.
    task automatic xfer(input int t, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int cyc);
        @(negedge pclk);
        tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1; cyc = 1;
        paddr = 8'($urandom); pwdata = 8'($urandom); pwrite = 1'($urandom);
        while (pready_m !== 1'b1 && cyc < 40) begin
            @(negedge pclk);
            cyc++;
            paddr = 8'($urandom); pwdata = 8'($urandom); pwrite = 1'($urandom);
        end
        rd = prdata_m; er = pslverr_m;
    endtask

    task automatic run(input int t, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input string tag);
        logic [7:0] rd;
        logic       er;
        int         cyc, idx;
        bit         bad;
        idx = int'(a[6:0]);
        bad = (idx >= 64);
        xfer(t, wr, a, d, rd, er, cyc);
        chk({tag, "_lat"}, cyc, wt[t] + 1);
        chk({tag, "_err"}, er, bad);
        if (!wr) chk({tag, "_rd"}, rd, bad ? 8'h00 : mdl[t][idx]);
        else if (!bad) mdl[t][idx] = d;
    endtask

    // Setup phase, then the first ACCESS cycle with psel/penable dropped.
    task automatic abort_xfer(input int t, input bit wr, input logic [7:0] a, input logic [7:0] d,
                              input string tag);
        @(negedge pclk);
        tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        chk({tag, "_abort_rdy"}, pready_m, 1'b0);
    endtask

    initial begin
        logic [7:0] a, d;
        int         t;
        bit         wr;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; tgt = 0;
        presetn = 1'b0;
        clear_model();
        repeat (3) @(negedge pclk);
        chk("rst_rdy0", if0.pready, 1'b0);
        chk("rst_err0", if0.pslverr, 1'b0);
        chk("rst_rd0", if0.prdata, 8'h00);
        chk("rst_rdy1", if1.pready, 1'b0);
        presetn = 1'b1;

        run(0, 0, 8'h05, 8'h00, "rst_read5");
        idle();

        // Access strobe with no setup phase must be ignored.
        @(negedge pclk);
        tgt = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h06; pwdata = 8'h99;
        @(negedge pclk);
        chk("nosetup_rdy_a", pready_m, 1'b0);
        @(negedge pclk);
        chk("nosetup_rdy_b", pready_m, 1'b0);
        idle();
        run(0, 0, 8'h06, 8'h00, "nosetup_rd");

        run(0, 1, 8'h12, 8'hA5, "w0_wr");
        run(0, 0, 8'h12, 8'h00, "w0_rd");
        idle();

        run(1, 1, 8'h01, 8'h3C, "w3_wr");
        run(1, 0, 8'h01, 8'h00, "w3_rd");
        idle();

        run(0, 1, 8'h45, 8'hFF, "oor_wr");
        run(0, 0, 8'h45, 8'h00, "oor_rd");
        run(0, 0, 8'h05, 8'h00, "oor_keep5");
        run(0, 0, 8'hC5, 8'h00, "hi_bit_ignored");
        idle();

        run(2, 1, 8'h08, 8'h5A, "ab_pre");
        idle();
        abort_xfer(2, 1, 8'h08, 8'h77, "ab");
        repeat (3) begin
            @(negedge pclk);
            chk("ab_rdy_stays0", pready_m, 1'b0);
        end
        run(2, 0, 8'h08, 8'h00, "ab_rd");
        idle();

        // Reset in the middle of a wait-stated write; prdata still holds 0x3C.
        run(1, 0, 8'h01, 8'h00, "mr_prime");
        @(negedge pclk);
        tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h11;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        chk("mr_rdy", pready_m, 1'b0);
        chk("mr_err", pslverr_m, 1'b0);
        chk("mr_rd", prdata_m, 8'h00);
        clear_model();
        idle();
        presetn = 1'b1;
        run(1, 0, 8'h02, 8'h00, "mr_after");
        run(1, 0, 8'h01, 8'h00, "mr_cleared");
        idle();

        for (int n = 0; n < 120; n++) begin
            t  = int'($urandom_range(0, 2));
            wr = 1'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {1'($urandom), 1'b0, 6'($urandom)};
            d  = 8'($urandom);
            if ($urandom_range(0, 9) == 0) abort_xfer(t, wr, a, d, "rnd");
            else run(t, wr, a, d, "rnd");
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
